// File: rtl/tinker_regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard for the pipelined Tinker core.
// Write port 0 retires ALU results; write port 1 retires long-latency results and releases busy.
module tinker_regfile_sb #(
  parameter int                DATA_W   = 64,
  parameter int                NREGS    = 32,
  parameter int                NREAD    = 3,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(64'h10000),
  parameter int                BYPASS   = 1,
  localparam int               AW       = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr0_en,
  input  logic [AW-1:0]           wr0_addr,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [AW-1:0]           wr1_addr,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic                    alloc_valid,
  input  logic [AW-1:0]           alloc_addr,
  output logic                    alloc_ready,
  input  logic                    flush,
  output logic [AW:0]             busy_count
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [AW-1:0]     rd_addr_a [NREAD];

  logic alloc_fire;
  logic count_inc;
  logic count_dec;

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rd_addr_a[i] = rd_addr[i*AW +: AW];
    end
  end

  // A register being released this cycle may be re-allocated in the same cycle.
  always_comb begin
    alloc_ready = !reset && !flush &&
                  (!busy[alloc_addr] || (wr1_en && (wr1_addr == alloc_addr)));
    alloc_fire  = alloc_valid && alloc_ready;
  end

  // NOTE: every output of this block is assigned a default before any condition, so no latch is inferred.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs[rd_addr_a[i]];
      rd_busy[i]                  = busy[rd_addr_a[i]];
      if ((BYPASS != 0) && !reset) begin
        if (wr1_en && (wr1_addr == rd_addr_a[i])) begin
          rd_data[i*DATA_W +: DATA_W] = wr1_data;
          rd_busy[i]                  = 1'b0;
        end else if (wr0_en && (wr0_addr == rd_addr_a[i])) begin
          rd_data[i*DATA_W +: DATA_W] = wr0_data;
        end
      end
    end
  end

  // NOTE: the array is reset explicitly because software relies on zeroed registers and a valid stack pointer.
  // Port 1 is written after port 0 so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == NREGS - 1) ? SP_RESET : '0;
      end
    end else begin
      if (wr0_en) regs[wr0_addr] <= wr0_data;
      if (wr1_en) regs[wr1_addr] <= wr1_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the later alloc assignment overrides a same-register release.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy <= '0;
    end else begin
      if (wr1_en)     busy[wr1_addr]   <= 1'b0;
      if (alloc_fire) busy[alloc_addr] <= 1'b1;
    end
  end

  // Count tracks popcount(busy) incrementally from the same set/clear decisions.
  always_comb begin
    count_inc = alloc_fire && !busy[alloc_addr];
    count_dec = wr1_en && busy[wr1_addr] && !(alloc_fire && (alloc_addr == wr1_addr));
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_count <= '0;
    end else if (count_inc && !count_dec) begin
      busy_count <= busy_count + (AW+1)'(1);
    end else if (count_dec && !count_inc) begin
      busy_count <= busy_count - (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Directed bench for tinker_regfile_sb: a bypassing and a non-bypassing instance share stimulus.
module tb_tinker_regfile_sb;

  localparam int DW = 64;
  localparam int NR = 3;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic [NR*AW-1:0] rd_addr;
  logic          wr0_en, wr1_en, alloc_valid, flush;
  logic [AW-1:0] wr0_addr, wr1_addr, alloc_addr;
  logic [DW-1:0] wr0_data, wr1_data;

  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NR-1:0]    rd_busy, rd_busy_nb;
  logic             alloc_ready, alloc_ready_nb;
  logic [AW:0]      busy_count, busy_count_nb;

  int tests = 0;
  int fails = 0;

  tinker_regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .flush(flush), .busy_count(busy_count)
  );

  tinker_regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready_nb),
    .flush(flush), .busy_count(busy_count_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input logic [NR*DW-1:0] v, input int p);
    return v[p*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; alloc_valid = 0; flush = 0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic test_reset();
    reset = 1; idle(); set_rd(0, 5, 31); alloc_addr = 0;
    step();
    #1;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL reset_alloc_ready: got %b want 0", alloc_ready); end
    reset = 0;
    #1;
    tests++; if (word(rd_data, 0) !== 64'h0) begin fails++; $display("FAIL reset_r0: got %h want 0", word(rd_data, 0)); end
    tests++; if (word(rd_data, 1) !== 64'h0) begin fails++; $display("FAIL reset_r5: got %h want 0", word(rd_data, 1)); end
    tests++; if (word(rd_data, 2) !== 64'h10000) begin fails++; $display("FAIL reset_r31: got %h want 10000", word(rd_data, 2)); end
    tests++; if (rd_busy !== 3'b000) begin fails++; $display("FAIL reset_busy: got %b want 000", rd_busy); end
    tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", busy_count); end
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", alloc_ready); end
  endtask

  task automatic test_write_bypass();
    wr0_en = 1; wr0_addr = 3; wr0_data = 64'hDEAD_BEEF; set_rd(3, 0, 31);
    #1;
    tests++; if (word(rd_data, 0) !== 64'hDEAD_BEEF) begin fails++; $display("FAIL wr0_bypass: got %h want deadbeef", word(rd_data, 0)); end
    tests++; if (word(rd_data_nb, 0) !== 64'h0) begin fails++; $display("FAIL wr0_nobypass: got %h want 0", word(rd_data_nb, 0)); end
    step(); idle();
    #1;
    tests++; if (word(rd_data, 0) !== 64'hDEAD_BEEF) begin fails++; $display("FAIL wr0_stored: got %h want deadbeef", word(rd_data, 0)); end
    tests++; if (word(rd_data_nb, 0) !== 64'hDEAD_BEEF) begin fails++; $display("FAIL wr0_stored_nb: got %h want deadbeef", word(rd_data_nb, 0)); end
  endtask

  task automatic test_write_collision();
    wr0_en = 1; wr0_addr = 7; wr0_data = 64'h1;
    wr1_en = 1; wr1_addr = 7; wr1_data = 64'h2;
    set_rd(7, 3, 31);
    #1;
    tests++; if (word(rd_data, 0) !== 64'h2) begin fails++; $display("FAIL coll_bypass: got %h want 2", word(rd_data, 0)); end
    tests++; if (word(rd_data, 1) !== 64'hDEAD_BEEF) begin fails++; $display("FAIL coll_other_port: got %h want deadbeef", word(rd_data, 1)); end
    step(); idle();
    #1;
    tests++; if (word(rd_data, 0) !== 64'h2) begin fails++; $display("FAIL coll_stored: got %h want 2", word(rd_data, 0)); end
    tests++; if (word(rd_data_nb, 0) !== 64'h2) begin fails++; $display("FAIL coll_stored_nb: got %h want 2", word(rd_data_nb, 0)); end
  endtask

  task automatic test_alloc();
    set_rd(0, 9, 0); alloc_valid = 1; alloc_addr = 9;
    #1;
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL alloc_ready_free: got %b want 1", alloc_ready); end
    step();
    #1;
    tests++; if (rd_busy[1] !== 1'b1) begin fails++; $display("FAIL alloc_busy: got %b want 1", rd_busy[1]); end
    tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL alloc_count: got %0d want 1", busy_count); end
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL realloc_refused: got %b want 0", alloc_ready); end
    step();
    tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL refused_count: got %0d want 1", busy_count); end
    wr1_en = 1; wr1_addr = 9; wr1_data = 64'h55;
    #1;
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL alloc_on_release: got %b want 1", alloc_ready); end
    tests++; if (rd_busy[1] !== 1'b0) begin fails++; $display("FAIL busy_bypass_mask: got %b want 0", rd_busy[1]); end
    tests++; if (rd_busy_nb[1] !== 1'b1) begin fails++; $display("FAIL busy_nobypass: got %b want 1", rd_busy_nb[1]); end
    tests++; if (word(rd_data, 1) !== 64'h55) begin fails++; $display("FAIL wr1_bypass: got %h want 55", word(rd_data, 1)); end
    step(); idle();
    #1;
    tests++; if (rd_busy[1] !== 1'b1) begin fails++; $display("FAIL alloc_wins_release: got %b want 1", rd_busy[1]); end
    tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL alloc_release_count: got %0d want 1", busy_count); end
    tests++; if (word(rd_data_nb, 1) !== 64'h55) begin fails++; $display("FAIL r9_data: got %h want 55", word(rd_data_nb, 1)); end
  endtask

  task automatic test_release();
    wr1_en = 1; wr1_addr = 9; wr1_data = 64'h77;
    step(); idle();
    #1;
    tests++; if (rd_busy[1] !== 1'b0) begin fails++; $display("FAIL release_busy: got %b want 0", rd_busy[1]); end
    tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL release_count: got %0d want 0", busy_count); end
    tests++; if (word(rd_data, 1) !== 64'h77) begin fails++; $display("FAIL release_data: got %h want 77", word(rd_data, 1)); end
  endtask

  task automatic test_back_to_back_flush();
    alloc_valid = 1; alloc_addr = 1; step();
    alloc_addr = 2; step();
    alloc_addr = 4; step();
    alloc_valid = 0; set_rd(1, 2, 4);
    #1;
    tests++; if (busy_count !== 6'd3) begin fails++; $display("FAIL b2b_count: got %0d want 3", busy_count); end
    tests++; if (rd_busy !== 3'b111) begin fails++; $display("FAIL b2b_busy: got %b want 111", rd_busy); end
    flush = 1; alloc_valid = 1; alloc_addr = 6;
    wr0_en = 1; wr0_addr = 6; wr0_data = 64'h66;
    #1;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL flush_refuses: got %b want 0", alloc_ready); end
    step(); idle(); set_rd(1, 6, 4);
    #1;
    tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", busy_count); end
    tests++; if (rd_busy !== 3'b000) begin fails++; $display("FAIL flush_busy: got %b want 000", rd_busy); end
    tests++; if (word(rd_data_nb, 1) !== 64'h66) begin fails++; $display("FAIL flush_write_kept: got %h want 66", word(rd_data_nb, 1)); end
  endtask

  task automatic test_mid_reset();
    alloc_valid = 1; alloc_addr = 4; wr0_en = 1; wr0_addr = 4; wr0_data = 64'hABC;
    step(); idle(); set_rd(4, 10, 31);
    #1;
    tests++; if (rd_busy[0] !== 1'b1 || word(rd_data, 0) !== 64'hABC) begin fails++; $display("FAIL pre_reset_r4: got busy=%b data=%h want 1 abc", rd_busy[0], word(rd_data, 0)); end
    reset = 1; wr0_en = 1; wr0_addr = 10; wr0_data = 64'h5;
    #1;
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_ready: got %b want 0", alloc_ready); end
    tests++; if (word(rd_data, 1) !== 64'h0) begin fails++; $display("FAIL reset_no_bypass: got %h want 0", word(rd_data, 1)); end
    step(); reset = 0; idle();
    #1;
    tests++; if (word(rd_data, 0) !== 64'h0) begin fails++; $display("FAIL mid_reset_r4: got %h want 0", word(rd_data, 0)); end
    tests++; if (word(rd_data, 1) !== 64'h0) begin fails++; $display("FAIL mid_reset_r10: got %h want 0", word(rd_data, 1)); end
    tests++; if (word(rd_data, 2) !== 64'h10000) begin fails++; $display("FAIL mid_reset_sp: got %h want 10000", word(rd_data, 2)); end
    tests++; if (rd_busy !== 3'b000 || busy_count !== 6'd0) begin fails++; $display("FAIL mid_reset_busy: got busy=%b count=%0d want 000 0", rd_busy, busy_count); end
  endtask

  initial begin
    reset = 1; rd_addr = '0; idle();
    wr0_addr = '0; wr1_addr = '0; alloc_addr = '0; wr0_data = '0; wr1_data = '0;
    test_reset();
    test_write_bypass();
    test_write_collision();
    test_alloc();
    test_release();
    test_back_to_back_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tinker_regfile_sb.md
Name: tinker_regfile_sb

Overview:
Parametrised register file with scoreboard. It is the successor to the single-cycle core's register file, for the multi-cycle/pipelined Tinker core.
- Provides NREAD combinational read ports with optional write-to-read bypass.
- Provides two write ports: port 0 for single-cycle ALU retire, port 1 for long-latency load/FPU retire.
- Tracks per-register busy bits so issue logic can stall on pending long-latency results.
- Sits between decode/issue and the execute/retire stages.

Parameters:
DATA_W, 64, register width in bits.
NREGS, 32, number of architectural registers (power of two, >=4); AW = $clog2(NREGS).
NREAD, 3, number of read ports (>=1).
SP_RESET, 64'h10000, reset value of register NREGS-1 (stack pointer); all others reset to 0.
BYPASS, 1, 1 = same-cycle write data and release are visible on read ports; 0 = reads return stored state only.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
rd_addr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
rd_data  out  NREAD*DATA_W  read data, port i at [i*DATA_W +: DATA_W].
rd_busy  out  NREAD  busy bit of each read address.
wr0_en  in  1  write port 0 enable (ALU retire).
wr0_addr  in  AW  write port 0 address.
wr0_data  in  DATA_W  write port 0 data.
wr1_en  in  1  write port 1 enable (long-latency retire); also releases the busy bit.
wr1_addr  in  AW  write port 1 address.
wr1_data  in  DATA_W  write port 1 data.
alloc_valid  in  1  issue requests to mark alloc_addr busy.
alloc_addr  in  AW  register to allocate.
alloc_ready  out  1  allocation accepted this cycle when alloc_valid && alloc_ready.
flush  in  1  clear all busy bits (pipeline flush).
busy_count  out  AW+1  number of busy registers.

Behaviour:
Reset:
- On posedge clk with reset=1: regs[0..NREGS-2]=0, regs[NREGS-1]=SP_RESET, all busy=0, busy_count=0.
- Writes, alloc and flush are ignored in that cycle.
- alloc_ready=0 combinationally while reset=1.
- rd_data/rd_busy reflect stored state; after the reset edge, reads return the reset values.

Writes:
- Both writes are registered on posedge clk.
- If wr0 and wr1 target the same address in the same cycle, wr1 wins.
- Writing via port 0 to a busy register updates data and leaves busy unchanged. This is legal and is not flagged.

Reads:
- Combinational, zero latency.
- BYPASS=1: if wr1_en && wr1_addr==rd_addr, rd_data=wr1_data; else if wr0_en && wr0_addr==rd_addr, rd_data=wr0_data; else the stored value.
- BYPASS=1: rd_busy = busy[addr] && !(wr1_en && wr1_addr==addr).
- BYPASS=0: both rd_data and rd_busy come from stored state only.
- Bypass is suppressed while reset=1.

Scoreboard, per register, next-state priority (highest first):
1. reset -> 0.
2. flush -> 0 for all registers. Alloc and release in the same cycle are ignored; the data write still occurs.
3. Accepted alloc to r -> busy[r]=1. An accepted alloc wins over a same-cycle release of r.
4. wr1_en to r -> busy[r]=0.

alloc_ready:
- alloc_ready = !reset && !flush && (!busy[alloc_addr] || (wr1_en && wr1_addr==alloc_addr)).
- alloc_ready is independent of alloc_valid.
- Allocating an already-busy register that is not being released is refused; issue holds alloc_valid until accepted.

busy_count:
- Registered; always equals the popcount of busy.
- +1 on accepted alloc of a non-releasing register; -1 on a release of a busy register with no same-register alloc; net 0 on same-register alloc+release.
- Alloc of register A with release of register B: net 0.
- Flush or reset sets it to 0.
- Never wraps: the range is 0..NREGS.

Register 0 is a normal register (not hardwired zero).

Test Plan:
- Reset then read: NREAD ports read r0, r5, r31 -> 0, 0, 64'h10000; rd_busy=0; busy_count=0.
- Write port 0 r3=64'hDEAD_BEEF with port 0 reading r3: same cycle BYPASS=1 -> DEAD_BEEF, BYPASS=0 -> old value 0; next cycle both show DEAD_BEEF.
- Simultaneous wr0(r7,64'h1) and wr1(r7,64'h2) -> r7=2 after the edge; bypassed read during the cycle = 2.
- alloc r9 -> rd_busy(r9)=1, busy_count=1. Re-alloc r9 -> alloc_ready=0. Same cycle wr1(r9,64'h55) with alloc r9 -> accepted; busy stays 1, busy_count stays 1, r9=55.
- Alloc r1,r2,r4 on successive cycles -> busy_count=3. Flush with alloc_valid r6 the same cycle -> alloc refused, all busy=0, busy_count=0.
- Mid-operation reset with r4 busy, r4=64'hABC, wr0(r10,5) pending -> next cycle r4=0, r10=0, busy=0, r31=64'h10000.
